// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte stream to 20x64 character memory writer with cursor and control codes (option: TEXT_CONSOLE_TAB_EN)
module text_console_writer #(
    parameter int         COLS   = 64,
    parameter int         ROWS   = 20,
    parameter int         ADDR_W = 16,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] char_write_addr,
    output logic [7:0]        char_write,
    output logic              wen,
    output logic              ren,
    output logic [4:0]        cursor_row,
    output logic [5:0]        cursor_col,
    output logic              busy
);
    localparam int COL_W   = $clog2(COLS);
    localparam int SWEEP_W = $clog2(ROWS * COLS);

    typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_SCREEN} state_t;

    state_t              state, state_n;
    logic [4:0]          row, row_n, row_inc;
    logic [COL_W-1:0]    col, col_n;
    logic [SWEEP_W-1:0]  sweep, sweep_n;
    logic                advance, advance_n;
    logic                wen_n;
    logic [7:0]          data_n;
    logic [ADDR_W-1:0]   addr_n;
    logic                accept;
`ifdef TEXT_CONSOLE_TAB_EN
    logic [COL_W:0]      tab_next;
`endif

    function automatic logic [ADDR_W-1:0] addr_of(input logic [4:0] r, input logic [COL_W-1:0] c);
        return ADDR_W'({r, c});
    endfunction

    assign in_ready   = (state == IDLE) && reset;
    assign accept     = in_valid && in_ready;
    assign ren        = 1'b0;
    assign busy       = (state != IDLE);
    assign cursor_row = row;
    assign cursor_col = 6'(col);
    assign row_inc    = (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;
`ifdef TEXT_CONSOLE_TAB_EN
    assign tab_next   = ({1'b0, col} | (COL_W+1)'(7)) + (COL_W+1)'(1);
`endif

    always_comb begin
        state_n   = state;
        row_n     = row;
        col_n     = col;
        sweep_n   = sweep;
        advance_n = advance;
        wen_n     = 1'b0;
        data_n    = char_write;
        addr_n    = char_write_addr;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wen_n     = 1'b1;
                        data_n    = in_data;
                        addr_n    = addr_of(row, col);
                        advance_n = 1'b1;
                        state_n   = WRITE;
                    end else begin
                        case (in_data)
                            8'h0D: col_n = '0;
                            8'h0A: begin
                                col_n   = '0;
                                row_n   = row_inc;
                                wen_n   = 1'b1;
                                data_n  = BLANK;
                                addr_n  = addr_of(row_inc, '0);
                                sweep_n = '0;
                                state_n = CLR_LINE;
                            end
                            8'h08: begin
                                // Backspace erases in place; the WRITE step must not re-advance
                                if (col != '0) begin
                                    col_n     = col - COL_W'(1);
                                    wen_n     = 1'b1;
                                    data_n    = BLANK;
                                    addr_n    = addr_of(row, col - COL_W'(1));
                                    advance_n = 1'b0;
                                    state_n   = WRITE;
                                end
                            end
                            8'h0C: begin
                                col_n   = '0;
                                row_n   = '0;
                                wen_n   = 1'b1;
                                data_n  = BLANK;
                                addr_n  = '0;
                                sweep_n = '0;
                                state_n = CLR_SCREEN;
                            end
`ifdef TEXT_CONSOLE_TAB_EN
                            8'h09: begin
                                if (tab_next >= (COL_W+1)'(COLS)) begin
                                    col_n   = '0;
                                    row_n   = row_inc;
                                    wen_n   = 1'b1;
                                    data_n  = BLANK;
                                    addr_n  = addr_of(row_inc, '0);
                                    sweep_n = '0;
                                    state_n = CLR_LINE;
                                end else begin
                                    col_n = tab_next[COL_W-1:0];
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                state_n = IDLE;
                if (advance) begin
                    if (col == COL_W'(COLS - 1)) begin
                        col_n   = '0;
                        row_n   = row_inc;
                        wen_n   = 1'b1;
                        data_n  = BLANK;
                        addr_n  = addr_of(row_inc, '0);
                        sweep_n = '0;
                        state_n = CLR_LINE;
                    end else begin
                        col_n = col + COL_W'(1);
                    end
                end
            end
            CLR_LINE: begin
                if (sweep == SWEEP_W'(COLS - 1)) begin
                    state_n = IDLE;
                end else begin
                    sweep_n = sweep + SWEEP_W'(1);
                    wen_n   = 1'b1;
                    data_n  = BLANK;
                    addr_n  = char_write_addr + ADDR_W'(1);
                end
            end
            CLR_SCREEN: begin
                if (sweep == SWEEP_W'(ROWS * COLS - 1)) begin
                    state_n = IDLE;
                end else begin
                    sweep_n = sweep + SWEEP_W'(1);
                    wen_n   = 1'b1;
                    data_n  = BLANK;
                    addr_n  = char_write_addr + ADDR_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            row             <= '0;
            col             <= '0;
            sweep           <= '0;
            advance         <= 1'b0;
            wen             <= 1'b0;
            char_write      <= 8'h00;
            char_write_addr <= '0;
        end else begin
            state           <= state_n;
            row             <= row_n;
            col             <= col_n;
            sweep           <= sweep_n;
            advance         <= advance_n;
            wen             <= wen_n;
            char_write      <= data_n;
            char_write_addr <= addr_n;
        end
    end
endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - scoreboard bench for text_console_writer
module tb_text_console_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [15:0] char_write_addr;
    logic [7:0]  char_write;
    logic        wen;
    logic        ren;
    logic [4:0]  cursor_row;
    logic [5:0]  cursor_col;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    text_console_writer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .char_write_addr(char_write_addr), .char_write(char_write),
        .wen(wen), .ren(ren), .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (wen) begin
            checks++;
            if (ren) begin
                errors++;
                $display("FAIL ren_with_wen got %0b want 0", ren);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got addr %0d data %0h want no write", char_write_addr, char_write);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if ({char_write_addr, char_write} !== e) begin
                    errors++;
                    $display("FAIL sb_write got addr %0d data %0h want addr %0d data %0h",
                             char_write_addr, char_write, e[23:8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int addr, input logic [7:0] d);
        exp_q.push_back({16'(addr), d});
    endtask

    task automatic push_line(input int row);
        for (int j = 0; j < 64; j++) push(row * 64 + j, 8'h20);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("send_timeout", 32'(n), 32'(0));
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h41;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        check({name, "_row"}, 32'(cursor_row), 32'(r));
        check({name, "_col"}, 32'(cursor_col), 32'(c));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wen", {31'd0, wen}, 32'd0);
        check("rst_ren", {31'd0, ren}, 32'd0);
        check("rst_addr", 32'(char_write_addr), 32'd0);
        check("rst_data", 32'(char_write), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_cursor("rst", 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Single printable byte
        push(0, 8'h41);
        send(8'h41);
        check("a_in_ready_low", {31'd0, in_ready}, 32'd0);
        wait_idle("a");
        check_cursor("a", 0, 1);

        // CR returns to column 0 without writing
        send(8'h0D);
        check("cr_in_ready", {31'd0, in_ready}, 32'd1);
        check_cursor("cr", 0, 0);

        // Full line then automatic clear of row 1
        for (int i = 0; i < 64; i++) push(i, 8'h30 + 8'(i));
        push_line(1);
        for (int i = 0; i < 64; i++) send(8'h30 + 8'(i));
        wait_idle("wrap");
        check_cursor("wrap", 1, 0);

        // Walk to row 19 col 5, then LF wraps to row 0
        for (int r = 2; r < 20; r++) push_line(r);
        for (int r = 2; r < 20; r++) send(8'h0A);
        for (int c = 0; c < 5; c++) push(19 * 64 + c, 8'h61 + 8'(c));
        for (int c = 0; c < 5; c++) send(8'h61 + 8'(c));
        wait_idle("r19");
        check_cursor("r19", 19, 5);
        push_line(0);
        send(8'h0A);
        wait_idle("lf_wrap");
        check_cursor("lf_wrap", 0, 0);

        // Backspace at 3,10 and at 3,0
        for (int r = 1; r < 4; r++) push_line(r);
        for (int r = 1; r < 4; r++) send(8'h0A);
        for (int c = 0; c < 10; c++) push(192 + c, 8'h4B);
        for (int c = 0; c < 10; c++) send(8'h4B);
        wait_idle("pos3_10");
        check_cursor("pos3_10", 3, 10);
        push(201, 8'h20);
        send(8'h08);
        wait_idle("bs");
        check_cursor("bs", 3, 9);
        send(8'h0D);
        send(8'h08);
        wait_idle("bs_col0");
        check_cursor("bs_col0", 3, 0);

        // Ignored bytes
        send(8'h7F);
        send(8'h01);
        send(8'hC3);
        wait_idle("ign");
        check_cursor("ign", 3, 0);

        // Tab from column 3
        for (int c = 0; c < 3; c++) push(192 + c, 8'h2E);
        for (int c = 0; c < 3; c++) send(8'h2E);
        send(8'h09);
        wait_idle("tab");
`ifdef TEXT_CONSOLE_TAB_EN
        check_cursor("tab", 3, 8);
`else
        check_cursor("tab", 3, 3);
`endif

        // Full form feed sweep
        for (int k = 0; k < 1280; k++) push(k, 8'h20);
        send(8'h0C);
        wait_idle("ff");
        check_cursor("ff", 0, 0);

        // Form feed aborted by reset after 500 sweep writes
        send(8'h42);
        push(0, 8'h42);
        wait_idle("pre_abort");
        for (int k = 0; k < 500; k++) push(k, 8'h20);
        send(8'h0C);
        repeat (499) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_wen", {31'd0, wen}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check_cursor("abort", 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
